// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the parametrised UART blocks.
//   parity_t   - parity mode encoding (none / odd / even).
//   rx_state_t - receiver FSM state encoding.
//   calc_div   - system clocks per oversample tick.
//                The future transmitter uses this helper as well.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: emits a one-cycle tick every DIV clocks.
//   clk   in  - system clock
//   rst   in  - synchronous active-low reset
//   clear in  - restarts the count so that ticks align to the current cycle
//   tick  out - registered one-cycle pulse
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Free-running divider; clear drops the count and suppresses the tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= {CW{1'b0}};
      r_tick <= 1'b0;
    end else if (clear) begin
      r_cnt  <= {CW{1'b0}};
      r_tick <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt  <= {CW{1'b0}};
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with a valid/ready output.
//   clk, rst   - system clock and synchronous active-low reset
//   rx         - asynchronous serial input; the line idles high
//   valid/ready- output handshake; a word transfers when both are high
//   data       - received word; the LSB is the first bit on the wire
//   frame_err  - a stop bit was sampled low for this word
//   parity_err - parity mismatch for this word
//   overrun    - sticky; set when a word is dropped, cleared by a handshake
//   busy       - the receiver is inside a frame
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE_HZ = 100_000_000,
  parameter int BAUD_RATE     = 9_600,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int OVERSAMPLE    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 ready,
  output logic                 busy
);

  localparam int DIV = calc_div(CLOCK_RATE_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int SW  = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int IW  = 4;
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic [1:0]    PAR_BITS  = PARITY[1:0];
  localparam parity_t       PMODE     = parity_t'(PAR_BITS);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  if (DIV < 1) begin : g_div_check
    $error("uart_rx_cfg: clock too slow for BAUD_RATE*OVERSAMPLE");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end

  // The result is 1 when the received parity bit disagrees with the selected mode.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic s,
                                      input parity_t m);
    logic odd_s;
    odd_s = (^d) ^ s;
    return (m == PARITY_ODD) ? ~odd_s : odd_s;
  endfunction

  logic                 r_sync1, r_sync2;
  rx_state_t            r_state;
  logic [SW-1:0]        r_scnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr, r_ferr, r_stop_idx, r_armed, r_done, r_busy;
  logic                 r_valid, r_frame_err, r_parity_err, r_overrun;
  logic [DATA_BITS-1:0] r_data;

  logic          w_rx, w_tick, w_clear, w_sample;
  logic [SW-1:0] w_cnt_last;

  // Two-flop synchroniser for the asynchronous line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  // A start edge counts only after the line has been seen high, so a held break gives one word.
  assign w_clear = (r_state == ST_IDLE) && r_armed && !w_rx;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // The start bit is sampled at mid-bit; every later bit is one full bit period on.
  always_comb begin
    w_cnt_last = FULL_LAST;
    if (r_state == ST_START) begin
      w_cnt_last = HALF_LAST;
    end else begin
      w_cnt_last = FULL_LAST;
    end
  end

  assign w_sample = w_tick && (r_scnt == w_cnt_last);

  // The receive FSM; it also holds the sample counter, shift register and error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_scnt     <= {SW{1'b0}};
      r_idx      <= {IW{1'b0}};
      r_shift    <= {DATA_BITS{1'b0}};
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_stop_idx <= 1'b0;
      r_armed    <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_clear) begin
        r_armed <= 1'b0;
      end else if (w_rx) begin
        r_armed <= 1'b1;
      end
      if (r_state == ST_IDLE || w_sample) begin
        r_scnt <= {SW{1'b0}};
      end else if (w_tick) begin
        r_scnt <= r_scnt + SW'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (w_clear) begin
            r_state    <= ST_START;
            r_busy     <= 1'b1;
            r_idx      <= {IW{1'b0}};
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_stop_idx <= 1'b0;
          end
        end
        ST_START: begin
          if (w_sample) begin
            if (w_rx) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DATA;
              r_idx   <= {IW{1'b0}};
            end
          end
        end
        ST_DATA: begin
          if (w_sample) begin
            r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
            if (r_idx == IDX_LAST) begin
              r_state <= (PMODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (w_sample) begin
            r_perr  <= parity_bad(r_shift, w_rx, PMODE);
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_sample) begin
            r_ferr <= r_ferr | ~w_rx;
            if (r_stop_idx == STOP_LAST) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // The output holding register. A word completing while the register is occupied is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid      <= 1'b0;
      r_data       <= {DATA_BITS{1'b0}};
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (r_done) begin
      if (!r_valid || ready) begin
        r_valid      <= 1'b1;
        r_data       <= r_shift;
        r_frame_err  <= r_ferr;
        r_parity_err <= r_perr;
        r_overrun    <= r_valid ? 1'b0 : r_overrun;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && ready) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign valid      = r_valid;
  assign data       = r_data;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for uart_rx_cfg using three configurations.
//   u0: 8N1 (main path, glitch, overrun, reset, break)
//   u1: 8E1 (parity)
//   u2: 8N2 (second stop bit)
// The clock is 1.6 MHz equivalent at 100 kbaud x16, so one bit lasts 16 clocks.
module tb_uart_rx_cfg;

  localparam int CLK_HZ   = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int OS       = 16;
  localparam int BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_i    [3];
  logic       ready_i [3];
  logic       valid_o [3];
  logic [7:0] data_o  [3];
  logic       fe_o    [3];
  logic       pe_o    [3];
  logic       ovr_o   [3];
  logic       busy_o  [3];

  int         acc_cnt   [3] = '{0, 0, 0};
  logic [7:0] last_data [3];
  logic       last_fe   [3];
  logic       last_pe   [3];
  int         n_pass  = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLOCK_RATE_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .OVERSAMPLE(OS)) u0 (
    .clk(clk), .rst(rst), .rx(rx_i[0]), .valid(valid_o[0]), .data(data_o[0]),
    .frame_err(fe_o[0]), .parity_err(pe_o[0]), .overrun(ovr_o[0]), .ready(ready_i[0]),
    .busy(busy_o[0]));

  uart_rx_cfg #(.CLOCK_RATE_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2),
                .STOP_BITS(1), .OVERSAMPLE(OS)) u1 (
    .clk(clk), .rst(rst), .rx(rx_i[1]), .valid(valid_o[1]), .data(data_o[1]),
    .frame_err(fe_o[1]), .parity_err(pe_o[1]), .overrun(ovr_o[1]), .ready(ready_i[1]),
    .busy(busy_o[1]));

  uart_rx_cfg #(.CLOCK_RATE_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(2), .OVERSAMPLE(OS)) u2 (
    .clk(clk), .rst(rst), .rx(rx_i[2]), .valid(valid_o[2]), .data(data_o[2]),
    .frame_err(fe_o[2]), .parity_err(pe_o[2]), .overrun(ovr_o[2]), .ready(ready_i[2]),
    .busy(busy_o[2]));

  // Records every accepted word, mid-cycle, after the stimulus has settled.
  always @(negedge clk) begin
    #1;
    for (int u = 0; u < 3; u++) begin
      if (valid_o[u] === 1'b1 && ready_i[u] === 1'b1) begin
        acc_cnt[u]   = acc_cnt[u] + 1;
        last_data[u] = data_o[u];
        last_fe[u]   = fe_o[u];
        last_pe[u]   = pe_o[u];
      end
    end
  end

  // Stops the run if the stimulus never completes.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int u, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_i[u] = bits[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx_i[u] = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b0;
    for (int u = 0; u < 3; u++) begin
      rx_i[u]    = 1'b1;
      ready_i[u] = 1'b1;
    end
    idle(3);
    chk("rst_valid", {31'd0, valid_o[0]}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o[0]},  32'd0);
    chk("rst_data",  {24'd0, data_o[0]},  32'd0);
    chk("rst_ovr",   {31'd0, ovr_o[0]},   32'd0);
    chk("rst_fe",    {31'd0, fe_o[0]},    32'd0);
    rst = 1'b1;
    idle(4);

    // 8N1 0xA5 with ready held high
    send_frame(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10);
    idle(8);
    chk("t1_count", acc_cnt[0], 32'd1);
    chk("t1_data",  {24'd0, last_data[0]}, 32'h0000_00A5);
    chk("t1_fe",    {31'd0, last_fe[0]}, 32'd0);
    chk("t1_pe",    {31'd0, last_pe[0]}, 32'd0);
    chk("t1_ovr",   {31'd0, ovr_o[0]},   32'd0);
    chk("t1_valid_pulse", {31'd0, valid_o[0]}, 32'd0);

    // Even parity: 0x03 has two ones, so the parity bit must be 0
    send_frame(1, {5'd0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
    idle(8);
    chk("t2_count_bad", acc_cnt[1], 32'd1);
    chk("t2_data_bad",  {24'd0, last_data[1]}, 32'h0000_0003);
    chk("t2_pe_bad",    {31'd0, last_pe[1]}, 32'd1);
    chk("t2_fe_bad",    {31'd0, last_fe[1]}, 32'd0);
    send_frame(1, {5'd0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
    idle(8);
    chk("t2_count_ok", acc_cnt[1], 32'd2);
    chk("t2_data_ok",  {24'd0, last_data[1]}, 32'h0000_0003);
    chk("t2_pe_ok",    {31'd0, last_pe[1]}, 32'd0);

    // Two stop bits, with the second one low
    send_frame(2, {5'd0, 1'b0, 1'b1, 8'h55, 1'b0}, 11);
    idle(8);
    chk("t3_count", acc_cnt[2], 32'd1);
    chk("t3_data",  {24'd0, last_data[2]}, 32'h0000_0055);
    chk("t3_fe",    {31'd0, last_fe[2]}, 32'd1);
    chk("t3_pe",    {31'd0, last_pe[2]}, 32'd0);
    chk("t3_busy1", {31'd0, busy_o[1]}, 32'd0);
    chk("t3_busy2", {31'd0, busy_o[2]}, 32'd0);
    chk("t3_ovr2",  {31'd0, ovr_o[2]},  32'd0);

    // 5-clock glitch: the start check at mid-bit sees the line high again
    rx_i[0] = 1'b0;
    idle(4);
    chk("t4_busy_mid", {31'd0, busy_o[0]}, 32'd1);
    idle(1);
    rx_i[0] = 1'b1;
    idle(7);
    chk("t4_busy_clk12", {31'd0, busy_o[0]}, 32'd0);
    idle(40);
    chk("t4_count", acc_cnt[0], 32'd1);
    chk("t4_valid", {31'd0, valid_o[0]}, 32'd0);

    // Overrun: two words while ready stays low
    ready_i[0] = 1'b0;
    send_frame(0, {6'd0, 1'b1, 8'h11, 1'b0}, 10);
    send_frame(0, {6'd0, 1'b1, 8'h22, 1'b0}, 10);
    idle(8);
    chk("t5_valid_held", {31'd0, valid_o[0]}, 32'd1);
    chk("t5_data_held",  {24'd0, data_o[0]},  32'h0000_0011);
    chk("t5_ovr_set",    {31'd0, ovr_o[0]},   32'd1);
    chk("t5_count_held", acc_cnt[0], 32'd1);
    ready_i[0] = 1'b1;
    idle(1);
    ready_i[0] = 1'b0;
    chk("t5_valid_drop", {31'd0, valid_o[0]}, 32'd0);
    chk("t5_ovr_clr",    {31'd0, ovr_o[0]},   32'd0);
    chk("t5_count_acc",  acc_cnt[0], 32'd2);
    chk("t5_data_acc",   {24'd0, last_data[0]}, 32'h0000_0011);
    idle(4);
    chk("t5_no_extra", {31'd0, valid_o[0]}, 32'd0);

    // Reset in the middle of the data bits
    ready_i[0] = 1'b1;
    rx_i[0] = 1'b0;
    idle(40);
    chk("t6_busy_pre", {31'd0, busy_o[0]}, 32'd1);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    rx_i[0] = 1'b1;
    chk("t6_rst_valid", {31'd0, valid_o[0]}, 32'd0);
    chk("t6_rst_busy",  {31'd0, busy_o[0]},  32'd0);
    chk("t6_rst_data",  {24'd0, data_o[0]},  32'd0);
    idle(200);
    chk("t6_no_word",   acc_cnt[0], 32'd2);
    send_frame(0, {6'd0, 1'b1, 8'h3C, 1'b0}, 10);
    idle(8);
    chk("t6_count", acc_cnt[0], 32'd3);
    chk("t6_data",  {24'd0, last_data[0]}, 32'h0000_003C);
    chk("t6_fe",    {31'd0, last_fe[0]}, 32'd0);

    // Break: a held-low line gives exactly one zero word with a framing error
    rx_i[0] = 1'b0;
    idle(200);
    rx_i[0] = 1'b1;
    idle(200);
    chk("t7_count", acc_cnt[0], 32'd4);
    chk("t7_data",  {24'd0, last_data[0]}, 32'd0);
    chk("t7_fe",    {31'd0, last_fe[0]}, 32'd1);
    chk("t7_busy",  {31'd0, busy_o[0]}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
